// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the frame sequencer and the I2S receiver.
package i2s_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN, STOP} i2s_seq_state_t;

  localparam int I2S_SLOT_W = 16;
  localparam int I2S_DIV_W  = 8;

endpackage

// File: rtl/i2s_clk_div.sv
// I2S bit-clock divider: sclk toggles every hd+1 clk cycles while run is high,
// with registered rise/fall strobes coincident with the sclk transition.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int DIV_W = I2S_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] hd,
  output logic             sclk,
  output logic             rise,
  output logic             fall,
  output logic             fall_next
);

  logic [DIV_W-1:0] div_cnt;
  logic             toggle;

  assign toggle    = run && (div_cnt == hd);
  // Lets the sequencer move ws on the same clk edge that drops sclk.
  assign fall_next = toggle && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else if (toggle) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
      rise    <= ~sclk;
      fall    <= sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_frame_sequencer.sv
// I2S master frame sequencer: sclk/ws generation, slot bit counting and a
// frame-done valid/ready handshake with overrun flag. Optional: I2S_OVERRUN_CNT_EN.
module i2s_frame_sequencer
  import i2s_pkg::*;
#(
  parameter int WIDTH = I2S_SLOT_W,
  parameter int DIV_W = I2S_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] half_div_i,
  output logic             sclk_o,
  output logic             ws_o,
  output logic             sclk_rise_o,
  output logic             sclk_fall_o,
  output logic             frame_start_o,
  output logic             pkt_valid_o,
  input  logic             pkt_ready_i,
  output logic             overrun_o,
  input  logic             clr_ovr_i,
`ifdef I2S_OVERRUN_CNT_EN
  output logic [15:0]      overrun_cnt_o,
`endif
  output logic             busy_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  i2s_seq_state_t   state;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] hd;
  logic [DIV_W-1:0] hd_req;
  logic             fall_next;
  logic             run;
  logic             wrap;
  logic             complete;
  logic             stopping;
  logic             set_ovr;

  assign hd_req   = (half_div_i == '0) ? DIV_W'(1) : half_div_i;
  assign run      = (state != IDLE);
  assign wrap     = (bit_cnt == CNT_W'(WIDTH - 1));
  // A frame ends on the fall that would take ws from the right slot back to left.
  assign complete = fall_next && wrap && ws_o && ((state == RUN) || (state == STOP));
  assign stopping = (state == STOP) && !en_i;
  assign set_ovr  = complete && pkt_valid_o && !pkt_ready_i;

  i2s_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .run       (run),
    .hd        (hd),
    .sclk      (sclk_o),
    .rise      (sclk_rise_o),
    .fall      (sclk_fall_o),
    .fall_next (fall_next)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      ws_o          <= 1'b1;
      frame_start_o <= 1'b0;
      busy_o        <= 1'b0;
      hd            <= DIV_W'(1);
    end else begin
      frame_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (en_i) begin
            state   <= START;
            busy_o  <= 1'b1;
            hd      <= hd_req;
            bit_cnt <= '0;
            ws_o    <= 1'b1;
          end
        end
        START: begin
          if (fall_next) begin
            ws_o          <= 1'b0;
            frame_start_o <= 1'b1;
            bit_cnt       <= '0;
            state         <= RUN;
          end
        end
        RUN, STOP: begin
          if ((state == RUN) && !en_i) state <= STOP;
          else if ((state == STOP) && en_i) state <= RUN;
          if (fall_next) begin
            if (!wrap) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              bit_cnt <= '0;
              // Stopping: the right slot has just finished, so park with ws high.
              if (ws_o && stopping) begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end else begin
                ws_o <= ~ws_o;
                if (ws_o) begin
                  frame_start_o <= 1'b1;
                  hd            <= hd_req;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pkt_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (complete) pkt_valid_o <= 1'b1;
      else if (pkt_ready_i) pkt_valid_o <= 1'b0;
      if (set_ovr) overrun_o <= 1'b1;
      else if (clr_ovr_i) overrun_o <= 1'b0;
    end
  end

`ifdef I2S_OVERRUN_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overrun_cnt_o <= '0;
    end else if (set_ovr) begin
      if (clr_ovr_i) overrun_cnt_o <= 16'd1;
      else if (overrun_cnt_o != 16'hFFFF) overrun_cnt_o <= overrun_cnt_o + 16'd1;
    end else if (clr_ovr_i) begin
      overrun_cnt_o <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Directed bench for i2s_frame_sequencer: a vector table of divider/handshake
// settings plus hand-written sequences for clear, stop, divider change and reset.
module tb_i2s_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ready = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] half_div = 8'd3;
  logic       sclk, ws, rise, fall, frame_start, valid, overrun, busy;
`ifdef I2S_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] hd;
    logic       rdy;
    int         period;
    int         valid_cycles;
    logic       ovr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  i2s_frame_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .en_i          (en),
    .half_div_i    (half_div),
    .sclk_o        (sclk),
    .ws_o          (ws),
    .sclk_rise_o   (rise),
    .sclk_fall_o   (fall),
    .frame_start_o (frame_start),
    .pkt_valid_o   (valid),
    .pkt_ready_i   (ready),
    .overrun_o     (overrun),
    .clr_ovr_i     (clr_ovr),
`ifdef I2S_OVERRUN_CNT_EN
    .overrun_cnt_o (ovr_cnt),
`endif
    .busy_o        (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] hd, input logic r, input logic c);
    en       = e;
    half_div = hd;
    ready    = r;
    clr_ovr  = c;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitFrameStart(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(ok), 32'd1);
  endtask

  task automatic waitFalls(input string name, input int n, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (fall) seen++;
    end
    checkOutput(name, 32'(seen), 32'(n));
  endtask

  initial begin
    int fs, cyc, last_rise, p, pmin, pmax, win_falls, win_low, total_falls;
    int first_valid_fall, vcyc, busy_low, falls, rises, fs_stop, phase;
    int wmin[2];
    int wmax[2];
    logic ovr_fs2;
    bit ok;

    vecs[0] = '{hd: 8'd3, rdy: 1'b1, period: 8,  valid_cycles: 1,   ovr: 1'b0};
    vecs[1] = '{hd: 8'd1, rdy: 1'b1, period: 4,  valid_cycles: 1,   ovr: 1'b0};
    vecs[2] = '{hd: 8'd0, rdy: 1'b1, period: 4,  valid_cycles: 1,   ovr: 1'b0};
    vecs[3] = '{hd: 8'd5, rdy: 1'b1, period: 12, valid_cycles: 1,   ovr: 1'b0};
    vecs[4] = '{hd: 8'd3, rdy: 1'b0, period: 8,  valid_cycles: 256, ovr: 1'b1};
    vecs[5] = '{hd: 8'd1, rdy: 1'b0, period: 4,  valid_cycles: 128, ovr: 1'b1};

    doReset();
    @(negedge clk);
    checkOutput("rst sclk", 32'(sclk), 32'd0);
    checkOutput("rst ws", 32'(ws), 32'd1);
    checkOutput("rst valid", 32'(valid), 32'd0);
    checkOutput("rst overrun", 32'(overrun), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst frame_start", 32'(frame_start), 32'd0);
`ifdef I2S_OVERRUN_CNT_EN
    checkOutput("rst ovr_cnt", 32'(ovr_cnt), 32'd0);
`endif

    // Two full frames per vector: timing, slot lengths and handshake.
    for (int v = 0; v < 6; v++) begin
      doReset();
      applyStimulus(1'b1, vecs[v].hd, vecs[v].rdy, 1'b0);
      fs = 0; cyc = 0; last_rise = -1; pmin = 100000; pmax = 0;
      win_falls = 0; win_low = 0; total_falls = 0; first_valid_fall = 0;
      vcyc = 0; busy_low = 0; ovr_fs2 = 1'b1;
      while (fs < 3 && cyc < 5000) begin
        @(negedge clk);
        cyc++;
        if (fall) total_falls++;
        if (frame_start) fs++;
        if (fs == 3) break;
        if (rise) begin
          if (last_rise >= 0) begin
            p = cyc - last_rise;
            if (p < pmin) pmin = p;
            if (p > pmax) pmax = p;
          end
          last_rise = cyc;
        end
        if (fall && fs >= 1) begin
          win_falls++;
          if (!ws) win_low++;
        end
        if (valid) begin
          vcyc++;
          if (first_valid_fall == 0) first_valid_fall = total_falls;
        end
        if (frame_start && fs == 2) ovr_fs2 = overrun;
        if (!busy) busy_low++;
      end
      checkOutput($sformatf("v%0d frames_reached", v), 32'(fs), 32'd3);
      checkOutput($sformatf("v%0d period_min", v), 32'(pmin), 32'(vecs[v].period));
      checkOutput($sformatf("v%0d period_max", v), 32'(pmax), 32'(vecs[v].period));
      checkOutput($sformatf("v%0d falls", v), 32'(win_falls), 32'd64);
      checkOutput($sformatf("v%0d ws_low_falls", v), 32'(win_low), 32'd32);
      checkOutput($sformatf("v%0d first_valid_fall", v), 32'(first_valid_fall), 32'd33);
      checkOutput($sformatf("v%0d valid_cycles", v), 32'(vcyc), 32'(vecs[v].valid_cycles));
      checkOutput($sformatf("v%0d overrun_frame1", v), 32'(ovr_fs2), 32'd0);
      checkOutput($sformatf("v%0d overrun_frame2", v), 32'(overrun), 32'(vecs[v].ovr));
      checkOutput($sformatf("v%0d busy_low", v), 32'(busy_low), 32'd0);
    end

    // Three unaccepted frames, then clear, set-beats-clear and accept.
    doReset();
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) waitFrameStart($sformatf("ovr fs%0d", k), 2000);
    checkOutput("ovr valid_held", 32'(valid), 32'd1);
    checkOutput("ovr sticky", 32'(overrun), 32'd1);
`ifdef I2S_OVERRUN_CNT_EN
    checkOutput("ovr cnt", 32'(ovr_cnt), 32'd2);
`endif
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ovr cleared", 32'(overrun), 32'd0);
`ifdef I2S_OVERRUN_CNT_EN
    checkOutput("ovr cnt cleared", 32'(ovr_cnt), 32'd0);
`endif
    waitFrameStart("ovr fs5", 2000);
    checkOutput("ovr set_wins", 32'(overrun), 32'd1);
`ifdef I2S_OVERRUN_CNT_EN
    checkOutput("ovr cnt set_wins", 32'(ovr_cnt), 32'd1);
`endif
    @(negedge clk);
    checkOutput("ovr clear_again", 32'(overrun), 32'd0);
    applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ovr accept", 32'(valid), 32'd0);

    // Drop en at left bit 5: the frame finishes, then the block parks.
    doReset();
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
    waitFrameStart("stop fs1", 2000);
    waitFalls("stop bit5", 5, 2000);
    applyStimulus(1'b0, 8'd3, 1'b1, 1'b0);
    falls = 0; fs_stop = 0; vcyc = 0; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fall) falls++;
      if (frame_start) fs_stop++;
      if (valid) vcyc++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("stop reached_idle", 32'(ok), 32'd1);
    checkOutput("stop remaining_falls", 32'(falls), 32'd27);
    checkOutput("stop no_frame_start", 32'(fs_stop), 32'd0);
    checkOutput("stop idle sclk", 32'(sclk), 32'd0);
    checkOutput("stop idle ws", 32'(ws), 32'd1);
    rises = 0; busy_low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rise) rises++;
      if (valid) vcyc++;
      if (busy) busy_low++;
    end
    checkOutput("stop valid_pulses", 32'(vcyc), 32'd1);
    checkOutput("stop idle rises", 32'(rises), 32'd0);
    checkOutput("stop idle busy", 32'(busy_low), 32'd0);

    // Divider change mid-frame applies from the next frame.
    doReset();
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
    waitFrameStart("div fs1", 2000);
    phase = 0; falls = 0; cyc = 0; last_rise = -1;
    wmin[0] = 100000; wmin[1] = 100000; wmax[0] = 0; wmax[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (frame_start) begin
        phase++;
        last_rise = -1;
        if (phase == 2) break;
      end
      if (fall && phase == 0) begin
        falls++;
        if (falls == 10) half_div = 8'd1;
      end
      if (rise) begin
        if (last_rise >= 0) begin
          p = cyc - last_rise;
          if (p < wmin[phase]) wmin[phase] = p;
          if (p > wmax[phase]) wmax[phase] = p;
        end
        last_rise = cyc;
      end
    end
    checkOutput("div frames_reached", 32'(phase), 32'd2);
    checkOutput("div old_min", 32'(wmin[0]), 32'd8);
    checkOutput("div old_max", 32'(wmax[0]), 32'd8);
    checkOutput("div new_min", 32'(wmin[1]), 32'd4);
    checkOutput("div new_max", 32'(wmax[1]), 32'd4);

    // Asynchronous reset in the middle of the right slot.
    doReset();
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
    waitFrameStart("arst fs1", 2000);
    waitFalls("arst right_slot", 20, 3000);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sclk) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("arst sclk_high", 32'(ok), 32'd1);
    checkOutput("arst in_right", 32'(ws), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst sclk", 32'(sclk), 32'd0);
    checkOutput("arst ws", 32'(ws), 32'd1);
    checkOutput("arst busy", 32'(busy), 32'd0);
    checkOutput("arst valid", 32'(valid), 32'd0);
    checkOutput("arst strobes", 32'({rise, fall, frame_start}), 32'd0);
    applyStimulus(1'b0, 8'd3, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vcyc = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (valid) vcyc++;
    end
    checkOutput("arst no_valid", 32'(vcyc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
